// File: rtl/rvv_backend_div_rs_pkg.sv
// Shared types and sizing for the vector divide reservation station.
// Stand-in for the rvv_backend.svh definitions of DIV_RS_t and NUM_DIV.
package rvv_backend_div_rs_pkg;

    localparam int unsigned NUM_DIV      = 2;
    localparam int unsigned DIV_NUM_PUSH = 2;
    localparam int unsigned DIV_RS_DEPTH = 8;

    typedef struct packed {
        logic [7:0]  tag;
        logic [4:0]  vd;
        logic [31:0] src1;
        logic [31:0] src2;
        logic        is_signed;
        logic        is_rem;
    } DIV_RS_t;

endpackage

// File: rtl/rvv_backend_div_rs_if.sv
// Dispatch-side and execute-side bundle of the divide reservation station.
interface rvv_backend_div_rs_if
    import rvv_backend_div_rs_pkg::*;
#(
    parameter int unsigned NUM_PUSH = DIV_NUM_PUSH,
    parameter int unsigned NUM_POP  = NUM_DIV
);

    logic [NUM_PUSH-1:0] push_valid_dp2rs;
    DIV_RS_t             div_uop_dp2rs [NUM_PUSH];
    logic                fifo_full_rs2dp;
    logic [NUM_PUSH-1:0] fifo_almost_full_rs2dp;
    DIV_RS_t             div_uop_rs2ex [NUM_POP];
    logic                fifo_empty_rs2ex;
    logic [NUM_POP-1:0]  fifo_almost_empty_rs2ex;
    logic [NUM_POP-1:0]  pop_ex2rs;

    // master: dispatch + DIV units; slave: the reservation station
    modport master (
        output push_valid_dp2rs, div_uop_dp2rs, pop_ex2rs,
        input  fifo_full_rs2dp, fifo_almost_full_rs2dp,
               div_uop_rs2ex, fifo_empty_rs2ex, fifo_almost_empty_rs2ex
    );

    modport slave (
        input  push_valid_dp2rs, div_uop_dp2rs, pop_ex2rs,
        output fifo_full_rs2dp, fifo_almost_full_rs2dp,
               div_uop_rs2ex, fifo_empty_rs2ex, fifo_almost_empty_rs2ex
    );

endinterface

// File: rtl/rvv_backend_mfifo.sv
// Generic in-order multi-push / multi-pop FIFO with show-ahead read ports.
// Flags decode registered count only; clear resets pointers and drops same-cycle traffic.
module rvv_backend_mfifo #(
    parameter type         T        = logic [7:0],
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned NUM_PUSH = 2,
    parameter int unsigned NUM_POP  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [NUM_PUSH-1:0]     push,
    input  T                        wdata [NUM_PUSH],
    input  logic [NUM_POP-1:0]      pop,
    output T                        rdata [NUM_POP],
    output logic                    full,
    output logic [NUM_PUSH-1:0]     almost_full,
    output logic                    empty,
    output logic [NUM_POP-1:0]      almost_empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    T                   mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   wr_idx [NUM_PUSH];
    logic [PTR_W-1:0]   rd_idx [NUM_POP];
    logic [NUM_PUSH-1:0] push_ok;
    logic [NUM_POP-1:0]  pop_ok;
    logic [CNT_W-1:0]   n_push;
    logic [CNT_W-1:0]   n_pop;

    // Acceptance uses the pre-cycle count: pops in the same cycle give no push credit.
    always_comb begin
        push_ok = '0;
        n_push  = '0;
        for (int unsigned j = 0; j < NUM_PUSH; j++) begin
            wr_idx[j] = wr_ptr + PTR_W'(j);
            if (push[j] && (32'(count) + j + 1 <= DEPTH)) begin
                push_ok[j] = 1'b1;
                n_push     = n_push + CNT_W'(1);
            end
        end
    end

    always_comb begin
        pop_ok = '0;
        n_pop  = '0;
        for (int unsigned i = 0; i < NUM_POP; i++) begin
            rd_idx[i] = rd_ptr + PTR_W'(i);
            rdata[i]  = mem[rd_idx[i]];
            if (pop[i] && (32'(count) >= i + 1)) begin
                pop_ok[i] = 1'b1;
                n_pop     = n_pop + CNT_W'(1);
            end
        end
    end

    always_comb begin
        full  = (32'(count) == DEPTH);
        empty = (count == '0);
        for (int unsigned j = 0; j < NUM_PUSH; j++)
            almost_full[j] = (32'(count) + j + 1 > DEPTH);
        for (int unsigned i = 0; i < NUM_POP; i++)
            almost_empty[i] = (32'(count) <= i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_push[PTR_W-1:0];
            rd_ptr <= rd_ptr + n_pop[PTR_W-1:0];
            count  <= count + n_push - n_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            for (int unsigned j = 0; j < NUM_PUSH; j++)
                if (push_ok[j])
                    mem[wr_idx[j]] <= wdata[j];
        end
    end

    a_push_prefix: assert property (@(posedge clk) disable iff (rst)
        ((push & (push + NUM_PUSH'(1))) == '0));
    a_pop_prefix: assert property (@(posedge clk) disable iff (rst)
        ((pop & (pop + NUM_POP'(1))) == '0));
    a_pop_in_range: assert property (@(posedge clk) disable iff (rst || clear)
        ((pop & almost_empty) == '0));
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        (32'(count) <= DEPTH));

endmodule

// File: rtl/rvv_backend_div_rs.sv
// Reservation station for the vector divide path: multi-port FIFO plus flush
// and dispatch/execute flag naming.
module rvv_backend_div_rs
    import rvv_backend_div_rs_pkg::*;
#(
    parameter int unsigned DEPTH    = DIV_RS_DEPTH,
    parameter int unsigned NUM_PUSH = DIV_NUM_PUSH,
    parameter int unsigned NUM_POP  = NUM_DIV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trap_flush_rvv,
    rvv_backend_div_rs_if.slave   rs_if
);

    logic [$clog2(DEPTH):0] count;

    rvv_backend_mfifo #(
        .T        (DIV_RS_t),
        .DEPTH    (DEPTH),
        .NUM_PUSH (NUM_PUSH),
        .NUM_POP  (NUM_POP)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .clear        (trap_flush_rvv),
        .push         (rs_if.push_valid_dp2rs),
        .wdata        (rs_if.div_uop_dp2rs),
        .pop          (rs_if.pop_ex2rs),
        .rdata        (rs_if.div_uop_rs2ex),
        .full         (rs_if.fifo_full_rs2dp),
        .almost_full  (rs_if.fifo_almost_full_rs2dp),
        .empty        (rs_if.fifo_empty_rs2ex),
        .almost_empty (rs_if.fifo_almost_empty_rs2ex),
        .count        (count)
    );

    a_count_bound_top: assert property (@(posedge clk) disable iff (rst)
        (32'(count) <= DEPTH));

endmodule

// File: tb/tb_rvv_backend_div_rs.sv
// Directed self-checking bench for rvv_backend_div_rs (DEPTH=8, 2 push, 2 pop).
module tb_rvv_backend_div_rs;
    import rvv_backend_div_rs_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trap_flush_rvv = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    rvv_backend_div_rs_if #(.NUM_PUSH(2), .NUM_POP(2)) rs_if ();

    rvv_backend_div_rs #(.DEPTH(8), .NUM_PUSH(2), .NUM_POP(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .trap_flush_rvv (trap_flush_rvv),
        .rs_if          (rs_if)
    );

    always #5 clk = ~clk;

    function automatic DIV_RS_t mk(input logic [7:0] t);
        DIV_RS_t u;
        u.tag       = t;
        u.vd        = t[4:0];
        u.src1      = {4{t}};
        u.src2      = ~{4{t}};
        u.is_signed = t[0];
        u.is_rem    = t[1];
        return u;
    endfunction

    task automatic idle();
        rs_if.push_valid_dp2rs = '0;
        rs_if.div_uop_dp2rs[0] = '0;
        rs_if.div_uop_dp2rs[1] = '0;
        rs_if.pop_ex2rs        = '0;
        trap_flush_rvv         = 1'b0;
    endtask

    // apply current inputs at the next edge, then return to idle 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic drive(input logic [1:0] pv, input logic [7:0] t0, input logic [7:0] t1,
                         input logic [1:0] pp);
        rs_if.push_valid_dp2rs = pv;
        rs_if.div_uop_dp2rs[0] = mk(t0);
        rs_if.div_uop_dp2rs[1] = mk(t1);
        rs_if.pop_ex2rs        = pp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        n_checks++; if (rs_if.fifo_empty_rs2ex !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b exp 1", rs_if.fifo_empty_rs2ex); end
        n_checks++; if (rs_if.fifo_almost_empty_rs2ex !== 2'b11) begin n_fail++; $display("FAIL reset_almost_empty: got %b exp 11", rs_if.fifo_almost_empty_rs2ex); end
        n_checks++; if (rs_if.fifo_full_rs2dp !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b exp 0", rs_if.fifo_full_rs2dp); end
        n_checks++; if (rs_if.fifo_almost_full_rs2dp !== 2'b00) begin n_fail++; $display("FAIL reset_almost_full: got %b exp 00", rs_if.fifo_almost_full_rs2dp); end
    endtask

    task automatic test_push_pop();
        drive(2'b11, 8'h10, 8'h11, 2'b00);
        n_checks++; if (rs_if.fifo_empty_rs2ex !== 1'b1) begin n_fail++; $display("FAIL pp_no_same_cycle: got %b exp 1", rs_if.fifo_empty_rs2ex); end
        step();
        n_checks++; if (rs_if.div_uop_rs2ex[0] !== mk(8'h10)) begin n_fail++; $display("FAIL pp_out0: got %h exp %h", rs_if.div_uop_rs2ex[0], mk(8'h10)); end
        n_checks++; if (rs_if.div_uop_rs2ex[1] !== mk(8'h11)) begin n_fail++; $display("FAIL pp_out1: got %h exp %h", rs_if.div_uop_rs2ex[1], mk(8'h11)); end
        n_checks++; if (rs_if.fifo_almost_empty_rs2ex !== 2'b00) begin n_fail++; $display("FAIL pp_almost_empty2: got %b exp 00", rs_if.fifo_almost_empty_rs2ex); end
        rs_if.pop_ex2rs = 2'b01;
        step();
        n_checks++; if (rs_if.div_uop_rs2ex[0] !== mk(8'h11)) begin n_fail++; $display("FAIL pp_after_pop: got %h exp %h", rs_if.div_uop_rs2ex[0], mk(8'h11)); end
        n_checks++; if (rs_if.fifo_almost_empty_rs2ex !== 2'b10) begin n_fail++; $display("FAIL pp_almost_empty1: got %b exp 10", rs_if.fifo_almost_empty_rs2ex); end
        rs_if.pop_ex2rs = 2'b01;
        step();
        n_checks++; if (rs_if.fifo_empty_rs2ex !== 1'b1) begin n_fail++; $display("FAIL pp_drained: got %b exp 1", rs_if.fifo_empty_rs2ex); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 8'(8'h20 + 2 * k), 8'(8'h21 + 2 * k), 2'b00);
            step();
        end
        drive(2'b01, 8'h26, 8'hEE, 2'b00);
        step();
        n_checks++; if (rs_if.fifo_almost_full_rs2dp !== 2'b10) begin n_fail++; $display("FAIL fill7_almost_full: got %b exp 10", rs_if.fifo_almost_full_rs2dp); end
        n_checks++; if (rs_if.fifo_full_rs2dp !== 1'b0) begin n_fail++; $display("FAIL fill7_full: got %b exp 0", rs_if.fifo_full_rs2dp); end
        drive(2'b11, 8'h27, 8'h28, 2'b00);
        step();
        n_checks++; if (rs_if.fifo_full_rs2dp !== 1'b1) begin n_fail++; $display("FAIL fill8_full: got %b exp 1", rs_if.fifo_full_rs2dp); end
        n_checks++; if (rs_if.fifo_almost_full_rs2dp !== 2'b11) begin n_fail++; $display("FAIL fill8_almost_full: got %b exp 11", rs_if.fifo_almost_full_rs2dp); end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (rs_if.div_uop_rs2ex[0] !== mk(8'(8'h20 + 2 * k))) begin n_fail++; $display("FAIL fill_drain0[%0d]: got %h exp %h", k, rs_if.div_uop_rs2ex[0], mk(8'(8'h20 + 2 * k))); end
            n_checks++; if (rs_if.div_uop_rs2ex[1] !== mk(8'(8'h21 + 2 * k))) begin n_fail++; $display("FAIL fill_drain1[%0d]: got %h exp %h", k, rs_if.div_uop_rs2ex[1], mk(8'(8'h21 + 2 * k))); end
            rs_if.pop_ex2rs = 2'b11;
            step();
        end
        n_checks++; if (rs_if.fifo_empty_rs2ex !== 1'b1) begin n_fail++; $display("FAIL fill_second_dropped: got empty=%b exp 1", rs_if.fifo_empty_rs2ex); end
    endtask

    task automatic test_full_push_pop();
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 8'(8'h30 + 2 * k), 8'(8'h31 + 2 * k), 2'b00);
            step();
        end
        n_checks++; if (rs_if.fifo_full_rs2dp !== 1'b1) begin n_fail++; $display("FAIL fpp_full: got %b exp 1", rs_if.fifo_full_rs2dp); end
        drive(2'b11, 8'h38, 8'h39, 2'b11);
        step();
        n_checks++; if (rs_if.fifo_full_rs2dp !== 1'b0) begin n_fail++; $display("FAIL fpp_not_full: got %b exp 0", rs_if.fifo_full_rs2dp); end
        n_checks++; if (rs_if.fifo_almost_full_rs2dp !== 2'b00) begin n_fail++; $display("FAIL fpp_almost_full6: got %b exp 00", rs_if.fifo_almost_full_rs2dp); end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (rs_if.div_uop_rs2ex[0] !== mk(8'(8'h32 + 2 * k))) begin n_fail++; $display("FAIL fpp_drain0[%0d]: got %h exp %h", k, rs_if.div_uop_rs2ex[0], mk(8'(8'h32 + 2 * k))); end
            n_checks++; if (rs_if.div_uop_rs2ex[1] !== mk(8'(8'h33 + 2 * k))) begin n_fail++; $display("FAIL fpp_drain1[%0d]: got %h exp %h", k, rs_if.div_uop_rs2ex[1], mk(8'(8'h33 + 2 * k))); end
            rs_if.pop_ex2rs = 2'b11;
            step();
        end
        n_checks++; if (rs_if.fifo_empty_rs2ex !== 1'b1) begin n_fail++; $display("FAIL fpp_count6: got empty=%b exp 1", rs_if.fifo_empty_rs2ex); end
    endtask

    task automatic test_wrap();
        logic [7:0] push_tag = 8'h40;
        logic [7:0] pop_tag  = 8'h40;
        int         cnt      = 0;
        for (int c = 0; c < 20; c++) begin
            drive(2'b11, push_tag, 8'(push_tag + 1), 2'b00);
            push_tag = 8'(push_tag + 2);
            if (cnt >= 2) begin
                n_checks++; if (rs_if.div_uop_rs2ex[0] !== mk(pop_tag)) begin n_fail++; $display("FAIL wrap0[%0d]: got %h exp %h", c, rs_if.div_uop_rs2ex[0], mk(pop_tag)); end
                n_checks++; if (rs_if.div_uop_rs2ex[1] !== mk(8'(pop_tag + 1))) begin n_fail++; $display("FAIL wrap1[%0d]: got %h exp %h", c, rs_if.div_uop_rs2ex[1], mk(8'(pop_tag + 1))); end
                rs_if.pop_ex2rs = 2'b11;
                pop_tag = 8'(pop_tag + 2);
                cnt = cnt - 2;
            end
            cnt = cnt + 2;
            step();
        end
        n_checks++; if (rs_if.div_uop_rs2ex[0] !== mk(pop_tag)) begin n_fail++; $display("FAIL wrap_last0: got %h exp %h", rs_if.div_uop_rs2ex[0], mk(pop_tag)); end
        n_checks++; if (rs_if.div_uop_rs2ex[1] !== mk(8'(pop_tag + 1))) begin n_fail++; $display("FAIL wrap_last1: got %h exp %h", rs_if.div_uop_rs2ex[1], mk(8'(pop_tag + 1))); end
        rs_if.pop_ex2rs = 2'b11;
        step();
        n_checks++; if (rs_if.fifo_empty_rs2ex !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b exp 1", rs_if.fifo_empty_rs2ex); end
    endtask

    task automatic test_flush();
        drive(2'b11, 8'h50, 8'h51, 2'b00); step();
        drive(2'b11, 8'h52, 8'h53, 2'b00); step();
        drive(2'b01, 8'h54, 8'hEE, 2'b00); step();
        drive(2'b11, 8'h55, 8'h56, 2'b11);
        trap_flush_rvv = 1'b1;
        step();
        n_checks++; if (rs_if.fifo_empty_rs2ex !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b exp 1", rs_if.fifo_empty_rs2ex); end
        n_checks++; if (rs_if.fifo_almost_empty_rs2ex !== 2'b11) begin n_fail++; $display("FAIL flush_almost_empty: got %b exp 11", rs_if.fifo_almost_empty_rs2ex); end
        n_checks++; if (rs_if.fifo_almost_full_rs2dp !== 2'b00) begin n_fail++; $display("FAIL flush_almost_full: got %b exp 00", rs_if.fifo_almost_full_rs2dp); end
        drive(2'b11, 8'h60, 8'h61, 2'b00);
        step();
        n_checks++; if (rs_if.div_uop_rs2ex[0] !== mk(8'h60)) begin n_fail++; $display("FAIL flush_refill0: got %h exp %h", rs_if.div_uop_rs2ex[0], mk(8'h60)); end
        n_checks++; if (rs_if.div_uop_rs2ex[1] !== mk(8'h61)) begin n_fail++; $display("FAIL flush_refill1: got %h exp %h", rs_if.div_uop_rs2ex[1], mk(8'h61)); end
        drive(2'b11, 8'h62, 8'h63, 2'b00);
        step();
        #2 rst = 1'b1;
        #1;
        n_checks++; if (rs_if.fifo_empty_rs2ex !== 1'b1) begin n_fail++; $display("FAIL async_rst_empty: got %b exp 1", rs_if.fifo_empty_rs2ex); end
        n_checks++; if (rs_if.fifo_almost_empty_rs2ex !== 2'b11) begin n_fail++; $display("FAIL async_rst_almost_empty: got %b exp 11", rs_if.fifo_almost_empty_rs2ex); end
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        n_checks++; if (rs_if.fifo_empty_rs2ex !== 1'b1) begin n_fail++; $display("FAIL post_rst_empty: got %b exp 1", rs_if.fifo_empty_rs2ex); end
    endtask

    initial begin
        idle();
        test_reset();
        test_push_pop();
        test_fill();
        test_full_push_pop();
        test_wrap();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
